// File: rtl/axi_rd_path.sv
// AXI4 read datapath in front of an SDRAM controller: splits AR bursts into BL8
// fetches, reserves buffer space per fetch and returns the data on the R channel.
module axi_rd_path #(
  parameter int ADDRS           = 32,
  parameter int WIDTH           = 32,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int CTRL_FIFO_DEPTH = 16,
  parameter int DATA_FIFO_DEPTH = 512,
  parameter bit AR_CHECKS       = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  input  logic [ADDRS-1:0]        axi_araddr_i,
  input  logic [AXI_ID_WIDTH-1:0] axi_arid_i,
  input  logic [7:0]              axi_arlen_i,
  input  logic [1:0]              axi_arburst_i,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i,
  output logic                    axi_rlast_o,
  output logic [1:0]              axi_rresp_o,
  output logic [AXI_ID_WIDTH-1:0] axi_rid_o,
  output logic [WIDTH-1:0]        axi_rdata_o,
  output logic                    mem_fetch_o,
  input  logic                    mem_accept_i,
  output logic                    mem_rseq_o,
  output logic [AXI_ID_WIDTH-1:0] mem_rdid_o,
  output logic [ADDRS-1:0]        mem_addr_o,
  input  logic                    mem_valid_i,
  input  logic                    mem_last_i,
  input  logic [WIDTH-1:0]        mem_data_i
);

  localparam int CHUNK_BYTES = 4 * WIDTH / 8;
  localparam int CHUNK_LSB   = $clog2(CHUNK_BYTES);
  localparam int CA_W        = $clog2(CTRL_FIFO_DEPTH);
  localparam int DA_W        = $clog2(DATA_FIFO_DEPTH);
  localparam int RES_W       = DA_W + 1;

  localparam logic [CA_W:0]      CTRL_FULL   = (CA_W+1)'(CTRL_FIFO_DEPTH);
  localparam logic [DA_W:0]      DATA_FULL   = (DA_W+1)'(DATA_FIFO_DEPTH);
  localparam logic [RES_W-1:0]   RES_LIMIT   = RES_W'(DATA_FIFO_DEPTH - 4);
  localparam logic [ADDRS-1:0]   CHUNK_STEP  = ADDRS'(CHUNK_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [7:0]              len;
    logic                    err;
  } req_t;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } word_t;

  state_t                  state, state_nx;
  logic                    out_en;
  logic                    ar_ready, fetch;
  logic                    ar_hs, fetch_hs, fetch_ok;
  logic [ADDRS-1:0]        addr_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [6:0]              chunks_q;
  logic                    rseq_q;
  logic [RES_W-1:0]        reserved;

  req_t                    ctrl_mem [CTRL_FIFO_DEPTH];
  logic [CA_W-1:0]         ctrl_wr, ctrl_rd;
  logic [CA_W:0]           ctrl_count;
  logic                    ctrl_full, ctrl_empty;
  req_t                    head;

  word_t                   data_mem [DATA_FIFO_DEPTH];
  logic [DA_W-1:0]         data_wr, data_rd;
  logic [DA_W:0]           data_count;
  logic                    data_full, data_empty, data_push;
  word_t                   head_word;

  logic [7:0]              beat_q;
  logic                    word_avail, beat_real, data_pop, req_end;

  assign ctrl_full  = (ctrl_count == CTRL_FULL);
  assign ctrl_empty = (ctrl_count == '0);
  assign data_full  = (data_count == DATA_FULL);
  assign data_empty = (data_count == '0);

  // Only issue a fetch when all four words it returns are guaranteed a slot.
  assign fetch_ok = (reserved <= RES_LIMIT);
  assign ar_hs    = axi_arvalid_i && ar_ready;
  assign fetch_hs = fetch && mem_accept_i;

  // out_en keeps arready low for the first cycle after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      out_en <= 1'b0;
    end else begin
      // NOTE: clocked state is always updated with non-blocking assignments so
      // every register samples the pre-edge values of its neighbours.
      state  <= state_nx;
      out_en <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_nx = state;
    ar_ready = 1'b0;
    fetch    = 1'b0;
    case (state)
      IDLE: begin
        ar_ready = out_en && !ctrl_full;
        if (axi_arvalid_i && ar_ready) state_nx = ISSUE;
      end
      ISSUE: begin
        fetch = fetch_ok;
        if (fetch && mem_accept_i && chunks_q == 7'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q   <= '0;
      id_q     <= '0;
      chunks_q <= '0;
      rseq_q   <= 1'b0;
    end else if (ar_hs) begin
      addr_q   <= {axi_araddr_i[ADDRS-1:CHUNK_LSB], {CHUNK_LSB{1'b0}}};
      id_q     <= axi_arid_i;
      chunks_q <= {1'b0, axi_arlen_i[7:2]} + 7'd1;
      rseq_q   <= 1'b0;
    end else if (fetch_hs) begin
      addr_q   <= addr_q + CHUNK_STEP;
      chunks_q <= chunks_q - 7'd1;
      rseq_q   <= 1'b1;
    end
  end

  // Accepted fetches add four words; every word leaving the data FIFO frees one.
  always_ff @(posedge clock) begin
    if (reset) begin
      reserved <= '0;
    end else begin
      reserved <= reserved + (fetch_hs ? RES_W'(4) : RES_W'(0))
                           - (data_pop ? RES_W'(1) : RES_W'(0));
    end
  end

  // NOTE: FIFO storage is deliberately not reset; validity is tracked solely by
  // the pointers and counts, which keeps the arrays mappable to RAM.
  always_ff @(posedge clock) begin
    if (ar_hs) ctrl_mem[ctrl_wr] <= '{id: axi_arid_i, len: axi_arlen_i,
                                      err: (axi_arburst_i != 2'b01)};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_wr    <= '0;
      ctrl_rd    <= '0;
      ctrl_count <= '0;
    end else begin
      if (ar_hs)   ctrl_wr <= ctrl_wr + 1'b1;
      if (req_end) ctrl_rd <= ctrl_rd + 1'b1;
      case ({ar_hs, req_end})
        2'b10:   ctrl_count <= ctrl_count + 1'b1;
        2'b01:   ctrl_count <= ctrl_count - 1'b1;
        default: ctrl_count <= ctrl_count;
      endcase
    end
  end

  assign data_push = mem_valid_i && !data_full;

  always_ff @(posedge clock) begin
    if (data_push) data_mem[data_wr] <= '{last: mem_last_i, data: mem_data_i};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_wr    <= '0;
      data_rd    <= '0;
      data_count <= '0;
    end else begin
      if (data_push) data_wr <= data_wr + 1'b1;
      if (data_pop)  data_rd <= data_rd + 1'b1;
      case ({data_push, data_pop})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
    end
  end

  // Words past arlen are chunk padding and drain without waiting for rready.
  assign head       = ctrl_mem[ctrl_rd];
  assign head_word  = data_mem[data_rd];
  assign word_avail = !data_empty && !ctrl_empty;
  assign beat_real  = (beat_q <= head.len);
  assign data_pop   = word_avail && (!beat_real || axi_rready_i);
  assign req_end    = data_pop && (beat_q == (head.len | 8'h03));

  always_ff @(posedge clock) begin
    if (reset)         beat_q <= '0;
    else if (req_end)  beat_q <= '0;
    else if (data_pop) beat_q <= beat_q + 8'd1;
  end

  assign axi_arready_o = ar_ready;
  assign axi_rvalid_o  = word_avail && beat_real;
  assign axi_rlast_o   = axi_rvalid_o && (beat_q == head.len);
  assign axi_rresp_o   = (axi_rvalid_o && head.err) ? 2'b10 : 2'b00;
  assign axi_rid_o     = head.id;
  assign axi_rdata_o   = head_word.data;
  assign mem_fetch_o   = fetch;
  assign mem_rseq_o    = rseq_q;
  assign mem_rdid_o    = id_q;
  assign mem_addr_o    = addr_q;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    mem_valid_i |-> !data_full)
    else $error("axi_rd_path: read-data FIFO overflow");

  a_last_aligned: assert property (@(posedge clock) disable iff (reset)
    data_pop |-> (head_word.last == (beat_q[1:0] == 2'b11)))
    else $error("axi_rd_path: mem_last does not line up with BL8 boundary");

  if (AR_CHECKS) begin : g_ar_checks
    a_ar_aligned: assert property (@(posedge clock) disable iff (reset)
      ar_hs |-> (axi_araddr_i[CHUNK_LSB-1:0] == '0))
      else $error("axi_rd_path: unaligned araddr %h", axi_araddr_i);

    a_ar_incr: assert property (@(posedge clock) disable iff (reset)
      ar_hs |-> (axi_arburst_i == 2'b01))
      else $error("axi_rd_path: unsupported arburst %b", axi_arburst_i);
  end

endmodule
